// File: rtl/multi_frame_buffer.sv
// multi_frame_buffer: N-way (2 or 3) frame buffer between a pixel producer
// and a display scan-out. The producer writes into wr_idx and the display
// reads from rd_idx. Buffers change hands only on commit and at the display
// frame boundary. A hardware clear fills the write buffer with CLEAR_VAL.
module multi_frame_buffer #(
  parameter int                DATA_W    = 12,
  parameter int                ADDR_W    = 10,
  parameter int                NUM_BUF   = 2,
  parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              w_en,
  input  logic [ADDR_W-1:0] w_addr,
  input  logic [DATA_W-1:0] w_data,
  output logic              w_ready,
  input  logic              commit,
  input  logic              clr_req,
  output logic              clr_busy,
  input  logic              frame_start,
  input  logic              r_en,
  input  logic [ADDR_W-1:0] r_addr,
  output logic [DATA_W-1:0] r_data,
  output logic              r_valid,
  output logic              swapped
);

  localparam int                DEPTH    = 2**ADDR_W;
  localparam int                BI_W     = (NUM_BUF > 2) ? 2 : 1;
  localparam bit                IS_DBL   = (NUM_BUF == 2);
  localparam logic [BI_W-1:0]   IDX_SUM  = BI_W'(3);
  localparam logic [BI_W-1:0]   RD_RST   = BI_W'(NUM_BUF - 1);
  localparam logic [ADDR_W-1:0] CNT_LAST = ADDR_W'(DEPTH - 1);

  generate
    if (NUM_BUF != 2 && NUM_BUF != 3) begin : g_bad_num_buf
      $error("multi_frame_buffer: NUM_BUF must be 2 or 3");
    end
  endgenerate

  typedef enum logic {S_IDLE, S_CLEAR} state_t;

  // Storage: one DEPTH-word bank per buffer, addressed as {buf_idx, addr}.
  logic [DATA_W-1:0] mem [NUM_BUF][DEPTH];

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [BI_W-1:0]   wr_idx_q, wr_idx_d;
  logic [BI_W-1:0]   rd_idx_q, rd_idx_d;
  logic [BI_W-1:0]   rdy_idx_q, rdy_idx_d;
  logic              rdy_valid_q, rdy_valid_d;
  logic              pending_q, pending_d;
  logic              swapped_q, swapped_d;
  logic [DATA_W-1:0] r_data_q, r_data_d;
  logic              r_valid_q, r_valid_d;

  logic              commit_acc;
  logic              clr_start;
  logic [BI_W-1:0]   free_idx;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  assign clr_busy   = (state_q == S_CLEAR);
  assign w_ready    = !clr_busy && !pending_q;
  assign commit_acc = commit && w_ready;
  // With two buffers a same-edge commit hands the write buffer to the
  // display side; clearing it would wipe the frame just committed.
  assign clr_start  = clr_req && w_ready && !(IS_DBL && commit);
  // Indices 0..2 sum to 3, so the third buffer is whatever is left over.
  assign free_idx   = IDX_SUM - wr_idx_q - rd_idx_q;

  // Clear sequencer: walk every address of the write buffer once.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (clr_start) begin
          state_d = S_CLEAR;
          cnt_d   = '0;
        end
      end
      S_CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Single memory write port shared by the clear engine and the producer.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = w_addr;
    mem_wdata = w_data;
    if (clr_busy) begin
      mem_we    = 1'b1;
      mem_waddr = cnt_q;
      mem_wdata = CLEAR_VAL;
    end else if (w_en && w_ready) begin
      mem_we = 1'b1;
    end
  end

  // Buffer index rotation on commit and at the display frame boundary.
  always_comb begin
    wr_idx_d    = wr_idx_q;
    rd_idx_d    = rd_idx_q;
    rdy_idx_d   = rdy_idx_q;
    rdy_valid_d = rdy_valid_q;
    pending_d   = pending_q;
    swapped_d   = 1'b0;
    if (IS_DBL) begin
      if (commit_acc) pending_d = 1'b1;
      if (frame_start && (pending_q || commit_acc)) begin
        wr_idx_d  = rd_idx_q;
        rd_idx_d  = wr_idx_q;
        pending_d = 1'b0;
        swapped_d = 1'b1;
      end
    end else begin
      if (commit_acc && frame_start && rdy_valid_q) begin
        rd_idx_d  = rdy_idx_q;
        rdy_idx_d = wr_idx_q;
        wr_idx_d  = rd_idx_q;
        swapped_d = 1'b1;
      end else if (commit_acc) begin
        // Newest frame wins: a stale ready frame is recycled as write buffer.
        rdy_idx_d   = wr_idx_q;
        rdy_valid_d = 1'b1;
        wr_idx_d    = rdy_valid_q ? rdy_idx_q : free_idx;
      end else if (frame_start && rdy_valid_q) begin
        rd_idx_d    = rdy_idx_q;
        rdy_valid_d = 1'b0;
        swapped_d   = 1'b1;
      end
    end
  end

  // Read port: capture the display buffer word, using rd_idx before any swap.
  always_comb begin
    r_data_d  = r_en ? mem[rd_idx_q][r_addr] : r_data_q;
    r_valid_d = r_en;
  end

  // Memory array write.
  always_ff @(posedge clk) begin
    if (mem_we) mem[wr_idx_q][mem_waddr] <= mem_wdata;
  end

  // Control and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      wr_idx_q    <= '0;
      rd_idx_q    <= RD_RST;
      rdy_idx_q   <= '0;
      rdy_valid_q <= 1'b0;
      pending_q   <= 1'b0;
      swapped_q   <= 1'b0;
      r_data_q    <= '0;
      r_valid_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wr_idx_q    <= wr_idx_d;
      rd_idx_q    <= rd_idx_d;
      rdy_idx_q   <= rdy_idx_d;
      rdy_valid_q <= rdy_valid_d;
      pending_q   <= pending_d;
      swapped_q   <= swapped_d;
      r_data_q    <= r_data_d;
      r_valid_q   <= r_valid_d;
    end
  end

  assign r_data  = r_data_q;
  assign r_valid = r_valid_q;
  assign swapped = swapped_q;

endmodule

// File: tb/tb_multi_frame_buffer.sv
// Bench for multi_frame_buffer: a double-buffer and a triple-buffer instance
// share one stimulus stream; reads push expected words into a queue that is
// drained as r_valid comes back.
module tb_multi_frame_buffer;

  logic        clk;
  logic        rst;
  logic        w_en;
  logic [9:0]  w_addr;
  logic [11:0] w_data;
  logic        commit;
  logic        clr_req;
  logic        frame_start;
  logic        r_en;
  logic [9:0]  r_addr;

  logic        w_ready2, clr_busy2, r_valid2, swapped2;
  logic [11:0] r_data2;
  logic        w_ready3, clr_busy3, r_valid3, swapped3;
  logic [11:0] r_data3;

  multi_frame_buffer #(.DATA_W(12), .ADDR_W(10), .NUM_BUF(2)) u_dut2 (
    .clk(clk), .rst(rst), .w_en(w_en), .w_addr(w_addr), .w_data(w_data),
    .w_ready(w_ready2), .commit(commit), .clr_req(clr_req),
    .clr_busy(clr_busy2), .frame_start(frame_start), .r_en(r_en),
    .r_addr(r_addr), .r_data(r_data2), .r_valid(r_valid2),
    .swapped(swapped2)
  );

  multi_frame_buffer #(.DATA_W(12), .ADDR_W(10), .NUM_BUF(3)) u_dut3 (
    .clk(clk), .rst(rst), .w_en(w_en), .w_addr(w_addr), .w_data(w_data),
    .w_ready(w_ready3), .commit(commit), .clr_req(clr_req),
    .clr_busy(clr_busy3), .frame_start(frame_start), .r_en(r_en),
    .r_addr(r_addr), .r_data(r_data3), .r_valid(r_valid3),
    .swapped(swapped3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [9:0]  addr;
    logic [11:0] data;
    logic [11:0] exp;
  } vec_t;

  vec_t        tbl [6];
  logic [11:0] exp_q [$];
  int          n_vec = 0;
  int          n_bad = 0;
  int          sw2 = 0;
  int          sw3 = 0;
  bit          en2 = 1'b0;
  bit          en3 = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Sample DUT outputs at the falling edge: pulse counters and read scoreboard.
  task automatic mon();
    logic [11:0] e;
    if (swapped2 === 1'b1) sw2++;
    if (swapped3 === 1'b1) sw3++;
    if ((en2 && r_valid2 === 1'b1) || (en3 && r_valid3 === 1'b1)) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL rd_unexpected: r_valid seen with no read outstanding");
      end else begin
        e = exp_q.pop_front();
        if (en2) begin
          check("r_valid2", 32'(r_valid2), 32'd1);
          check("r_data2", 32'(r_data2), 32'(e));
        end
        if (en3) begin
          check("r_valid3", 32'(r_valid3), 32'd1);
          check("r_data3", 32'(r_data3), 32'(e));
        end
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    mon();
  endtask

  task automatic wr(input logic [9:0] a, input logic [11:0] d);
    w_en = 1'b1; w_addr = a; w_data = d;
    tick();
    w_en = 1'b0;
  endtask

  task automatic rd(input logic [9:0] a, input logic [11:0] e);
    r_en = 1'b1; r_addr = a;
    exp_q.push_back(e);
    tick();
    r_en = 1'b0;
  endtask

  task automatic commit_p();
    commit = 1'b1;
    tick();
    commit = 1'b0;
  endtask

  task automatic fs_p();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic drain();
    tick();
    check("rd_drain", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    int n, n3, sb2, sb3;
    rst = 1'b0; w_en = 1'b0; w_addr = '0; w_data = '0; commit = 1'b0;
    clr_req = 1'b0; frame_start = 1'b0; r_en = 1'b0; r_addr = '0;
    tbl[0] = '{10'd5,    12'hABC, 12'hABC};
    tbl[1] = '{10'd0,    12'h001, 12'h001};
    tbl[2] = '{10'd1023, 12'hFFF, 12'hFFF};
    tbl[3] = '{10'd512,  12'h5A5, 12'h5A5};
    tbl[4] = '{10'd7,    12'h123, 12'h7E7};
    tbl[5] = '{10'd7,    12'h7E7, 12'h7E7};

    // Reset state
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    check("rst_clr_busy2", 32'(clr_busy2), 32'd0);
    check("rst_r_valid2",  32'(r_valid2),  32'd0);
    check("rst_r_data2",   32'(r_data2),   32'd0);
    check("rst_swapped2",  32'(swapped2),  32'd0);
    check("rst_w_ready2",  32'(w_ready2),  32'd1);
    check("rst_clr_busy3", 32'(clr_busy3), 32'd0);
    check("rst_r_valid3",  32'(r_valid3),  32'd0);
    check("rst_r_data3",   32'(r_data3),   32'd0);
    check("rst_swapped3",  32'(swapped3),  32'd0);
    check("rst_w_ready3",  32'(w_ready3),  32'd1);

    // Table frame: write, commit, dropped write while pending, swap, read back
    en2 = 1'b1; en3 = 1'b1;
    foreach (tbl[i]) wr(tbl[i].addr, tbl[i].data);
    commit_p();
    check("pend_w_ready2", 32'(w_ready2), 32'd0);
    check("commit_w_ready3", 32'(w_ready3), 32'd1);
    wr(10'd7, 12'h999);
    sb2 = sw2; sb3 = sw3;
    fs_p();
    check("fs_swapped2", 32'(swapped2), 32'd1);
    check("fs_swapped3", 32'(swapped3), 32'd1);
    check("swap_w_ready2", 32'(w_ready2), 32'd1);
    foreach (tbl[i]) rd(tbl[i].addr, tbl[i].exp);
    fs_p();
    check("idle_fs_swapped2", 32'(swapped2), 32'd0);
    check("idle_fs_swapped3", 32'(swapped3), 32'd0);
    check("swap_count2", 32'(sw2 - sb2), 32'd1);
    check("swap_count3", 32'(sw3 - sb3), 32'd1);
    drain();

    // Hardware clear: exactly DEPTH busy cycles, then display the cleared frame
    clr_req = 1'b1; tick(); clr_req = 1'b0;
    check("clr_w_ready2", 32'(w_ready2), 32'd0);
    n = 0; n3 = 0;
    while (clr_busy2 === 1'b1 && n < 2000) begin
      n++;
      if (clr_busy3 === 1'b1) n3++;
      tick();
    end
    check("clr_cycles2", 32'(n), 32'd1024);
    check("clr_cycles3", 32'(n3), 32'd1024);
    commit_p();
    // Read on the frame_start cycle still sees the outgoing buffer
    frame_start = 1'b1; r_en = 1'b1; r_addr = 10'd5;
    exp_q.push_back(12'hABC);
    tick();
    frame_start = 1'b0; r_en = 1'b0;
    rd(10'd0, 12'h000);
    rd(10'd511, 12'h000);
    rd(10'd1023, 12'h000);
    drain();

    // Reset in the middle of a clear
    clr_req = 1'b1; tick(); clr_req = 1'b0;
    repeat (20) tick();
    check("midclr_busy2", 32'(clr_busy2), 32'd1);
    rst = 1'b1; tick(); rst = 1'b0;
    check("rstclr_busy2", 32'(clr_busy2), 32'd0);
    check("rstclr_busy3", 32'(clr_busy3), 32'd0);
    check("rstclr_w_ready2", 32'(w_ready2), 32'd1);
    wr(10'd9, 12'h5A5);
    rd(10'd9, 12'h000);
    commit_p();
    fs_p();
    rd(10'd9, 12'h5A5);
    drain();

    // Triple buffering only
    en2 = 1'b0; en3 = 1'b1;
    rst = 1'b1; tick(); rst = 1'b0;
    wr(10'd0, 12'h111);
    commit_p();
    check("tri_w_ready_a", 32'(w_ready3), 32'd1);
    wr(10'd0, 12'h222);
    commit_p();
    check("tri_w_ready_b", 32'(w_ready3), 32'd1);
    sb3 = sw3;
    fs_p();
    check("tri_fs_swapped", 32'(swapped3), 32'd1);
    rd(10'd0, 12'h222);
    wr(10'd0, 12'h333);
    commit_p();
    wr(10'd0, 12'h444);
    commit = 1'b1; frame_start = 1'b1; r_en = 1'b1; r_addr = 10'd0;
    exp_q.push_back(12'h222);
    tick();
    commit = 1'b0; frame_start = 1'b0; r_en = 1'b0;
    check("tri_cfs_swapped", 32'(swapped3), 32'd1);
    check("tri_cfs_w_ready", 32'(w_ready3), 32'd1);
    rd(10'd0, 12'h333);
    fs_p();
    check("tri_next_swapped", 32'(swapped3), 32'd1);
    rd(10'd0, 12'h444);
    fs_p();
    check("tri_empty_fs", 32'(swapped3), 32'd0);
    rd(10'd0, 12'h444);
    check("tri_swap_count", 32'(sw3 - sb3), 32'd3);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
